mdu_unit: RTL and testbench

- Multiply/divide unit in the E stage of the pipelined MIPS core.
- Consumes E-stage operands and the decoded MD op from the datapath.
- Owns the HI/LO registers and signals Busy to the hazard unit, which stalls D-stage MD instructions.
- Results are computed at Start, held in pending registers, and committed to HI/LO after a fixed latency.

---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mdu_compute.sv | 51 +++++
 rtl/mdu_unit.sv | 128 ++++++++++++
 tb/tb_mdu_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: MDUOp codes, FSM states, default latencies.
// The madd/msub encodings are only accepted by the unit when MDU_MADD_EN is defined.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5,
        MDU_MADD  = 3'd6,
        MDU_MSUB  = 3'd7
    } mdu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu_compute.sv
// Combinational MD datapath: 64-bit product or {remainder, quotient} plus a divide-by-zero flag.
// madd/msub share the signed product; accumulation happens in the top at commit (MDU_MADD_EN).
module mdu_compute
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic [63:0] sext_a;
    logic [63:0] sext_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] safe_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    always_comb begin
        sext_a      = {{32{a[31]}}, a};
        sext_b      = {{32{b[31]}}, b};
        // Signed division works on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
        mag_a       = a[31] ? (~a + 32'd1) : a;
        mag_b       = b[31] ? (~b + 32'd1) : b;
        safe_b      = (b == 32'd0) ? 32'd1 : b;
        if (mag_b == 32'd0) begin
            mag_b = 32'd1;
        end
        q_mag       = mag_a / mag_b;
        r_mag       = mag_a % mag_b;
        quot        = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
        rem         = a[31] ? (~r_mag + 32'd1) : r_mag;
        result      = '0;
        div_by_zero = 1'b0;
        case (op)
            MDU_MULT, MDU_MADD, MDU_MSUB: result = sext_a * sext_b;
            MDU_MULTU:                    result = {32'd0, a} * {32'd0, b};
            MDU_DIV:                      result = {rem, quot};
            MDU_DIVU:                     result = {a % safe_b, a / safe_b};
            default:                      result = '0;
        endcase
        if ((op == MDU_DIV || op == MDU_DIVU) && b == 32'd0) begin
            div_by_zero = 1'b1;
        end
    end

endmodule

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit: owns HI/LO, latches results at Start and commits after a fixed latency.
// Define MDU_MADD_EN to accept MDUOp 6/7 as madd/msub; otherwise those codes are ignored.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    mdu_state_e  state_reg;
    logic [3:0]  cnt_reg;
    logic [63:0] pend_reg;
    logic        write_reg;
    logic [63:0] result;
    logic        div_by_zero;
    logic [63:0] commit_value;

    mdu_compute u_compute (
        .op          (MDUOp),
        .a           (A),
        .b           (B),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

`ifdef MDU_MADD_EN
    logic [1:0] acc_reg;  // 0: overwrite, 1: accumulate, 2: subtract

    always_comb begin
        commit_value = pend_reg;
        if (acc_reg == 2'd1) begin
            commit_value = {HI, LO} + pend_reg;
        end else if (acc_reg == 2'd2) begin
            commit_value = {HI, LO} - pend_reg;
        end
    end
`else
    always_comb begin
        commit_value = pend_reg;
    end
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            pend_reg  <= '0;
            write_reg <= 1'b0;
            Busy      <= 1'b0;
            HI        <= '0;
            LO        <= '0;
`ifdef MDU_MADD_EN
            acc_reg   <= 2'd0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (Start) begin
                        case (MDUOp)
                            MDU_MULT, MDU_MULTU: begin
                                pend_reg  <= result;
                                write_reg <= 1'b1;
                                cnt_reg   <= 4'(MULT_CYCLES);
                                state_reg <= RUN;
                                Busy      <= 1'b1;
`ifdef MDU_MADD_EN
                                acc_reg   <= 2'd0;
`endif
                            end
                            MDU_DIV, MDU_DIVU: begin
                                // A zero divisor still occupies the unit but never commits.
                                pend_reg  <= result;
                                write_reg <= ~div_by_zero;
                                cnt_reg   <= 4'(DIV_CYCLES);
                                state_reg <= RUN;
                                Busy      <= 1'b1;
`ifdef MDU_MADD_EN
                                acc_reg   <= 2'd0;
`endif
                            end
                            MDU_MTHI: HI <= A;
                            MDU_MTLO: LO <= A;
`ifdef MDU_MADD_EN
                            MDU_MADD, MDU_MSUB: begin
                                pend_reg  <= result;
                                write_reg <= 1'b1;
                                cnt_reg   <= 4'(MULT_CYCLES);
                                state_reg <= RUN;
                                Busy      <= 1'b1;
                                acc_reg   <= (MDUOp == MDU_MADD) ? 2'd1 : 2'd2;
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    // Start is deliberately not looked at here: the hazard unit must hold MD ops off.
                    if (cnt_reg == 4'd1) begin
                        state_reg <= IDLE;
                        Busy      <= 1'b0;
                        cnt_reg   <= 4'd0;
                        if (write_reg) begin
                            {HI, LO} <= commit_value;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    Busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: reset, mult/div arithmetic, latency, divide-by-zero, ignored Start.
// Exercises madd/msub when MDU_MADD_EN is defined, otherwise checks that ops 6/7 are ignored.
module tb_mdu_unit;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [2:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int total;
    int bad;

    mdu_unit dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .MDUOp (MDUOp),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Pulses Start for one cycle, then scrambles operands to show they are sampled only at Start.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        MDUOp = op;
        A     = a;
        B     = b;
        tick();
        Start = 1'b0;
        MDUOp = 3'd0;
        A     = 32'hDEADBEEF;
        B     = 32'h12345678;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (Busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        start_op(op, a, b);
        count_busy(n);
        total++;
        if (n !== exp_n) begin
            bad++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, n, exp_n);
        end
        total++;
        if (HI !== exp_hi) begin
            bad++;
            $display("FAIL %s HI: got %h expected %h", name, HI, exp_hi);
        end
        total++;
        if (LO !== exp_lo) begin
            bad++;
            $display("FAIL %s LO: got %h expected %h", name, LO, exp_lo);
        end
        $display("op %s a=%h b=%h busy=%0d HI=%h LO=%h", name, a, b, n, HI, LO);
    endtask

    task automatic move_op(input string name, input logic [2:0] op, input logic [31:0] v,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        start_op(op, v, 32'd0);
        total++;
        if (Busy !== 1'b0) begin
            bad++;
            $display("FAIL %s busy: got %b expected 0", name, Busy);
        end
        total++;
        if (HI !== exp_hi || LO !== exp_lo) begin
            bad++;
            $display("FAIL %s hilo: got %h_%h expected %h_%h", name, HI, LO, exp_hi, exp_lo);
        end
        $display("op %s v=%h HI=%h LO=%h", name, v, HI, LO);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tick();
        total++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            bad++;
            $display("FAIL reset_state: got busy=%b %h_%h expected 0 00000000_00000000", Busy, HI, LO);
        end
        Reset = 1'b0;
        tick();
        $display("reset busy=%b HI=%h LO=%h", Busy, HI, LO);
    endtask

    task automatic test_mult();
        run_op("mult",  3'd0, 32'hFFFFFFFF, 32'h00000002, 5, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("multu", 3'd1, 32'hFFFFFFFF, 32'h00000002, 5, 32'h00000001, 32'hFFFFFFFE);
    endtask

    task automatic test_div();
        run_op("div_neg",  3'd2, 32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_ovf",  3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);
        run_op("divu",     3'd3, 32'd100,      32'd7,        10, 32'd2,        32'd14);
    endtask

    task automatic test_div_zero();
        move_op("mthi", 3'd4, 32'h11, 32'h11, 32'd14);
        move_op("mtlo", 3'd5, 32'h22, 32'h11, 32'h22);
        run_op("divu_zero", 3'd3, 32'd1234, 32'd0, 10, 32'h11, 32'h22);
    endtask

    task automatic test_busy_ignore();
        int n;
        start_op(3'd3, 32'd100, 32'd7);
        n = 0;
        while (Busy === 1'b1 && n < 40) begin
            n++;
            if (n == 3) begin
                Start = 1'b1;
                MDUOp = 3'd0;
                A     = 32'd3;
                B     = 32'd5;
            end else begin
                Start = 1'b0;
            end
            tick();
        end
        Start = 1'b0;
        total++;
        if (n !== 10) begin
            bad++;
            $display("FAIL busy_ignore busy_cycles: got %0d expected 10", n);
        end
        total++;
        if (HI !== 32'd2 || LO !== 32'd14) begin
            bad++;
            $display("FAIL busy_ignore hilo: got %h_%h expected 00000002_0000000e", HI, LO);
        end
        tick();
        tick();
        total++;
        if (Busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_ignore late_busy: got %b expected 0", Busy);
        end
        $display("busy_ignore busy=%0d HI=%h LO=%h", n, HI, LO);
    endtask

    task automatic test_reset_mid();
        start_op(3'd0, 32'd7, 32'd9);
        tick();
        Reset = 1'b1;
        #1;
        total++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            bad++;
            $display("FAIL reset_mid async: got busy=%b %h_%h expected 0 00000000_00000000", Busy, HI, LO);
        end
        tick();
        Reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        total++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            bad++;
            $display("FAIL reset_mid no_commit: got busy=%b %h_%h expected 0 00000000_00000000", Busy, HI, LO);
        end
        $display("reset_mid busy=%b HI=%h LO=%h", Busy, HI, LO);
    endtask

`ifdef MDU_MADD_EN
    task automatic test_madd();
        move_op("mthi0", 3'd4, 32'h0, 32'h0, 32'h0);
        move_op("mtlo_ff", 3'd5, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF);
        run_op("madd", 3'd6, 32'd1, 32'd1, 5, 32'h00000001, 32'h00000000);
        run_op("msub", 3'd7, 32'd1, 32'd1, 5, 32'h00000000, 32'hFFFFFFFF);
    endtask
`else
    task automatic test_madd();
        move_op("mthi55", 3'd4, 32'h55, 32'h55, 32'h0);
        move_op("mtlo66", 3'd5, 32'h66, 32'h55, 32'h66);
        move_op("rsvd6", 3'd6, 32'd1, 32'h55, 32'h66);
        move_op("rsvd7", 3'd7, 32'd1, 32'h55, 32'h66);
        for (int i = 0; i < 6; i++) tick();
        total++;
        if (Busy !== 1'b0 || HI !== 32'h55 || LO !== 32'h66) begin
            bad++;
            $display("FAIL rsvd_late: got busy=%b %h_%h expected 0 00000055_00000066", Busy, HI, LO);
        end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        Reset = 1'b1;
        Start = 1'b0;
        MDUOp = 3'd0;
        A     = 32'd0;
        B     = 32'd0;
        #1;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_busy_ignore();
        test_reset_mid();
        test_madd();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
